// File: rtl/spart_bus_arbiter.sv
// Two-requester round-robin arbiter in front of a SPART register port.
// Each transaction is latched in IDLE, waits for rda/tbr with a timeout, then does a single-cycle bus access.
module spart_bus_arbiter #(
    parameter logic [7:0] WAIT_MAX = 8'd255
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req0,
    input  logic       req1,
    input  logic       rw0,
    input  logic       rw1,
    input  logic [1:0] addr0,
    input  logic [1:0] addr1,
    input  logic [7:0] wdata0,
    input  logic [7:0] wdata1,
    output logic       gnt0,
    output logic       gnt1,
    output logic       done0,
    output logic       done1,
    output logic       err,
    output logic [7:0] rdata,
    input  logic       rda,
    input  logic       tbr,
    output logic       iocs,
    output logic       iorw,
    output logic [1:0] ioaddr,
    inout  wire  [7:0] databus
);

    typedef enum logic [1:0] {IDLE, WAIT, XFER, DONE} state_t;

    state_t     state_q, state_d;
    logic       owner_q, owner_d;
    logic       rw_q, rw_d;
    logic [1:0] addr_q, addr_d;
    logic [7:0] wdata_q, wdata_d;
    logic [7:0] cnt_q, cnt_d;
    logic       lastGnt_q, lastGnt_d;
    logic       err_q, err_d;
    logic [7:0] rdata_q, rdata_d;

    logic       pick;
    logic       ready;
    logic [7:0] cntInc;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            owner_q   <= 1'b0;
            rw_q      <= 1'b1;
            addr_q    <= 2'b00;
            wdata_q   <= 8'h00;
            cnt_q     <= 8'h00;
            lastGnt_q <= 1'b1;
            err_q     <= 1'b0;
            rdata_q   <= 8'h00;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            rw_q      <= rw_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            cnt_q     <= cnt_d;
            lastGnt_q <= lastGnt_d;
            err_q     <= err_d;
            rdata_q   <= rdata_d;
        end
    end

    // lastGnt_q starts at 1 so requester 0 wins the first contested arbitration.
    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        rw_d      = rw_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        cnt_d     = cnt_q;
        lastGnt_d = lastGnt_q;
        err_d     = err_q;
        rdata_d   = rdata_q;
        pick      = (req0 && req1) ? ~lastGnt_q : req1;
        cntInc    = cnt_q + 8'd1;
        ready     = 1'b1;
        if (addr_q == 2'b00) begin
            ready = rw_q ? rda : tbr;
        end

        unique case (state_q)
            IDLE: begin
                if (req0 || req1) begin
                    owner_d = pick;
                    rw_d    = pick ? rw1 : rw0;
                    addr_d  = pick ? addr1 : addr0;
                    wdata_d = pick ? wdata1 : wdata0;
                    cnt_d   = 8'h00;
                    err_d   = 1'b0;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (ready) begin
                    state_d = XFER;
                end else begin
                    cnt_d = cntInc;
                    if (cntInc == WAIT_MAX) begin
                        err_d   = 1'b1;
                        state_d = DONE;
                    end
                end
            end
            XFER: begin
                err_d   = 1'b0;
                state_d = DONE;
                if (rw_q) begin
                    rdata_d = databus;
                end
            end
            DONE: begin
                lastGnt_d = owner_q;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign gnt0    = (state_q != IDLE) && !owner_q;
    assign gnt1    = (state_q != IDLE) && owner_q;
    assign done0   = (state_q == DONE) && !owner_q;
    assign done1   = (state_q == DONE) && owner_q;
    assign err     = (state_q == DONE) && err_q;
    assign rdata   = rdata_q;
    assign iocs    = (state_q == XFER);
    assign iorw    = iocs ? rw_q : 1'b1;
    assign ioaddr  = iocs ? addr_q : 2'b00;
    assign databus = (iocs && !rw_q) ? wdata_q : 8'hzz;

endmodule

// File: tb/tb_spart_bus_arbiter.sv
// Randomized scoreboard bench for spart_bus_arbiter: two requester processes, a SPART model
// and a monitor that checks arbitration, bus cycles and completions against a transaction-level model.
module tb_spart_bus_arbiter;

    localparam logic [7:0] WAIT_MAX = 8'd6;
    localparam int NTXN = 30;

    typedef struct {
        logic       rw;
        logic [1:0] addr;
        logic [7:0] wdata;
        int         delay;
        logic [7:0] sdata;
    } txn_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       req0, req1, rw0, rw1;
    logic [1:0] addr0, addr1;
    logic [7:0] wdata0, wdata1;
    logic       gnt0, gnt1, done0, done1, err;
    logic [7:0] rdata;
    logic       rda, tbr;
    logic       iocs, iorw;
    logic [1:0] ioaddr;
    wire  [7:0] databus;
    logic [7:0] spartData;

    int   checks = 0;
    int   errors = 0;
    txn_t q0[$];
    txn_t q1[$];
    bit   monOn = 1'b0;

    spart_bus_arbiter #(.WAIT_MAX(WAIT_MAX)) dut (
        .clk(clk), .rst(rst),
        .req0(req0), .req1(req1), .rw0(rw0), .rw1(rw1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1),
        .err(err), .rdata(rdata), .rda(rda), .tbr(tbr),
        .iocs(iocs), .iorw(iorw), .ioaddr(ioaddr), .databus(databus)
    );

    // SPART side: drives read data only while the arbiter is doing a read access.
    assign databus = (iocs && iorw) ? spartData : 8'hzz;
    for (genvar i = 0; i < 8; i++) begin : g_pull
        pullup pu (databus[i]);
    end

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, "_gnt"},     32'({gnt1, gnt0}),   32'd0);
        checkOutput({tag, "_done"},    32'({done1, done0}), 32'd0);
        checkOutput({tag, "_err"},     32'(err),            32'd0);
        checkOutput({tag, "_rdata"},   32'(rdata),          32'h00);
        checkOutput({tag, "_iocs"},    32'(iocs),           32'd0);
        checkOutput({tag, "_iorw"},    32'(iorw),           32'd1);
        checkOutput({tag, "_ioaddr"},  32'(ioaddr),         32'd0);
        checkOutput({tag, "_databus"}, 32'(databus),        32'hFF);
    endtask

    function automatic txn_t makeTxn(input int id, input int n);
        txn_t t;
        t.rw    = 1'($urandom_range(0, 1));
        t.addr  = 2'($urandom_range(0, 3));
        t.wdata = 8'($urandom);
        t.sdata = 8'($urandom);
        t.delay = int'($urandom_range(0, 32'(WAIT_MAX) + 2));
        if (id == 0 && n == 0) t = '{1'b0, 2'b10, 8'h80, 0, 8'h00};
        if (id == 0 && n == 1) t = '{1'b0, 2'b00, 8'h3C, int'(WAIT_MAX) + 2, 8'h00};
        if (id == 0 && n == 2) t = '{1'b0, 2'b00, 8'h11, 3, 8'h00};
        if (id == 1 && n == 0) t = '{1'b1, 2'b00, 8'h00, 5, 8'h5A};
        if (id == 1 && n == 1) t = '{1'b1, 2'b00, 8'h00, int'(WAIT_MAX) - 1, 8'hA5};
        if (id == 1 && n == 2) t = '{1'b1, 2'b00, 8'h00, int'(WAIT_MAX), 8'h77};
        return t;
    endfunction

    task automatic driveReq(input int id, input logic r, input txn_t t);
        if (id == 0) begin
            req0 = r; rw0 = t.rw; addr0 = t.addr; wdata0 = t.wdata;
        end else begin
            req1 = r; rw1 = t.rw; addr1 = t.addr; wdata1 = t.wdata;
        end
    endtask

    // One requester: issue, scramble inputs once granted, wait for done, then hold or release req.
    task automatic applyStimulus(input int id);
        txn_t t;
        int   waited;
        bit   seenDone;
        bit   hold;
        for (int n = 0; n < NTXN; n++) begin
            t = makeTxn(id, n);
            @(posedge clk); #1;
            if (id == 0) q0.push_back(t); else q1.push_back(t);
            driveReq(id, 1'b1, t);
            waited   = 0;
            seenDone = 1'b0;
            while (!seenDone && waited < 200) begin
                @(negedge clk);
                waited++;
                if ((id == 0) ? done0 : done1) seenDone = 1'b1;
                else if ((id == 0) ? gnt0 : gnt1) driveReq(id, 1'b1, makeTxn(id, 99));
            end
            checkOutput($sformatf("req%0d_completes", id), 32'(seenDone), 32'd1);
            hold = ($urandom_range(0, 3) == 0);
            if (!hold) begin
                @(posedge clk); #1;
                driveReq(id, 1'b0, makeTxn(id, 99));
                repeat ($urandom_range(0, 3)) @(posedge clk);
            end
        end
        @(posedge clk); #1;
        driveReq(id, 1'b0, makeTxn(id, 99));
    endtask

    // Monitor plus SPART readiness model; all sampling on the falling edge.
    bit         pg0 = 0, pg1 = 0, pReq0 = 0, pReq1 = 0;
    bit         active = 0;
    int         curOwner = 0;
    int         lastGranted = 1;
    int         gntCnt, xferCnt, expWin, expCycles;
    bit         expErr, rdy;
    logic [7:0] modelRdata = 8'h00;
    txn_t       cur;

    initial begin
        forever begin
            @(negedge clk);
            if (monOn) begin
                checkOutput("gnt_exclusive", 32'(gnt0 && gnt1), 32'd0);
                if ((gnt0 || gnt1) && !(pg0 || pg1)) begin
                    if (pReq0 && pReq1) expWin = 1 - lastGranted;
                    else if (pReq1)     expWin = 1;
                    else if (pReq0)     expWin = 0;
                    else                expWin = -1;
                    curOwner = gnt1 ? 1 : 0;
                    checkOutput("arb_winner", 32'(curOwner), 32'(expWin));
                    gntCnt  = 0;
                    xferCnt = 0;
                    active  = ((curOwner == 0) ? q0.size() : q1.size()) > 0;
                    checkOutput("sb_has_txn", 32'(active), 32'd1);
                    if (active) cur = (curOwner == 0) ? q0[0] : q1[0];
                end
                if (active && (gnt0 || gnt1)) begin
                    rdy = (gntCnt >= cur.delay);
                    if (cur.addr == 2'b00) begin
                        rda = cur.rw ? rdy : !rdy;
                        tbr = cur.rw ? !rdy : rdy;
                    end else begin
                        rda = 1'b0;
                        tbr = 1'b0;
                    end
                    spartData = cur.sdata;
                    gntCnt++;
                end else begin
                    rda = 1'b0;
                    tbr = 1'b0;
                end
                if (iocs) begin
                    xferCnt++;
                    checkOutput("xfer_iorw", 32'(iorw), 32'(cur.rw));
                    checkOutput("xfer_ioaddr", 32'(ioaddr), 32'(cur.addr));
                    if (!cur.rw) checkOutput("xfer_wdata", 32'(databus), 32'(cur.wdata));
                end else begin
                    checkOutput("idle_bus", 32'({iorw, ioaddr}), 32'b100);
                    checkOutput("idle_databus", 32'(databus), 32'hFF);
                end
                if (done0 || done1) begin
                    expErr    = (cur.addr == 2'b00) && (cur.delay >= int'(WAIT_MAX));
                    expCycles = expErr ? int'(WAIT_MAX) + 1 : ((cur.addr == 2'b00) ? cur.delay + 3 : 3);
                    checkOutput("done_active", 32'(active), 32'd1);
                    checkOutput("done_owner", 32'({done1, done0}), (curOwner == 1) ? 32'd2 : 32'd1);
                    checkOutput("done_err", 32'(err), 32'(expErr));
                    checkOutput("gnt_cycles", 32'(gntCnt), 32'(expCycles));
                    checkOutput("xfer_cycles", 32'(xferCnt), expErr ? 32'd0 : 32'd1);
                    if (!expErr && cur.rw) modelRdata = cur.sdata;
                    if (curOwner == 0 && q0.size() > 0) void'(q0.pop_front());
                    if (curOwner == 1 && q1.size() > 0) void'(q1.pop_front());
                    lastGranted = curOwner;
                    active      = 1'b0;
                end else begin
                    checkOutput("err_without_done", 32'(err), 32'd0);
                end
                checkOutput("rdata", 32'(rdata), 32'(modelRdata));
            end
            pg0   = gnt0;
            pg1   = gnt1;
            pReq0 = req0;
            pReq1 = req1;
        end
    end

    initial begin
        txn_t t;
        bit   found;
        rst = 1'b1;
        req0 = 0; req1 = 0; rw0 = 1; rw1 = 1; addr0 = 0; addr1 = 0; wdata0 = 0; wdata1 = 0;
        rda = 0; tbr = 0; spartData = 8'h00;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkResetValues("por");
        @(posedge clk); #1;
        rst   = 1'b0;
        monOn = 1'b1;
        fork
            applyStimulus(0);
            applyStimulus(1);
        join
        repeat (4) @(negedge clk);
        checkOutput("sb_drained", 32'(q0.size() + q1.size()), 32'd0);
        monOn = 1'b0;

        // Requester 0 completes a read so requester 1 would hold priority without a reset.
        spartData = 8'hE7;
        @(posedge clk); #1;
        t = '{1'b1, 2'b01, 8'h00, 0, 8'h00};
        driveReq(0, 1'b1, t);
        found = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clk);
            if (done0) found = 1;
        end
        checkOutput("pre_rst_done", 32'(found), 32'd1);
        @(posedge clk); #1;
        t = '{1'b0, 2'b01, 8'hC3, 0, 8'h00};
        driveReq(0, 1'b1, t);
        found = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clk);
            if (iocs) found = 1;
        end
        checkOutput("rst_xfer_reached", 32'(found), 32'd1);
        checkOutput("rst_xfer_databus", 32'(databus), 32'hC3);
        rst  = 1'b1;
        req0 = 1'b0;
        @(negedge clk);
        checkResetValues("mid_xfer");
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (3) begin
            @(negedge clk);
            checkOutput("no_done_after_rst", 32'({done1, done0}), 32'd0);
        end
        @(posedge clk); #1;
        req0 = 1'b1;
        req1 = 1'b1;
        found = 0;
        for (int i = 0; i < 10 && !found; i++) begin
            @(negedge clk);
            if (gnt0 || gnt1) found = 1;
        end
        checkOutput("rst_priority", 32'({gnt1, gnt0}), 32'b01);
        @(posedge clk); #1;
        req0 = 1'b0;
        req1 = 1'b0;
        repeat (8) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
